// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single memory port; one transaction in flight.
// Read done LATENCY+3 cycles after grant, write LATENCY+2; requesters hold until done.
module mem_arbiter #(
  parameter int unsigned LATENCY = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  a_rw,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic [15:0] a_rdata,
  output logic        a_done,
  input  logic [1:0]  b_rw,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic [15:0] b_rdata,
  output logic        b_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        owner,
  output logic [1:0]  err
);

  localparam logic [1:0] RW_RD  = 2'b01;
  localparam logic [1:0] RW_WT  = 2'b10;
  localparam logic [1:0] RW_ILL = 2'b11;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic [1:0]  err_q, err_d;

  logic a_req, b_req, grant_b;
  logic [1:0] own_rw;

  assign a_req  = (a_rw == RW_RD) || (a_rw == RW_WT);
  assign b_req  = (b_rw == RW_RD) || (b_rw == RW_WT);
  // With both requesting, the one that did not finish last wins.
  assign grant_b = b_req && (!a_req || !last_owner_q);
  assign own_rw  = owner_q ? b_rw : a_rw;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    err_d        = err_q;

    if ((state_q == S_WAIT || state_q == S_ACCESS || state_q == S_CAPTURE) &&
        (own_rw != rw_q)) begin
      err_d[0] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (a_rw == RW_ILL || b_rw == RW_ILL) err_d[1] = 1'b1;
        if (a_req || b_req) begin
          owner_d = grant_b;
          rw_d    = grant_b ? b_rw    : a_rw;
          addr_d  = grant_b ? b_addr  : a_addr;
          wdata_d = grant_b ? b_wdata : a_wdata;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_ACCESS: begin
        state_d = (rw_q == RW_WT) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (owner_q) b_rdata_d = mem_rdata;
        else         a_rdata_d = mem_rdata;
        state_d = S_DONE;
      end
      S_DONE: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      rw_q         <= 2'b00;
      addr_q       <= 16'd0;
      wdata_q      <= 16'd0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      a_rdata_q    <= 16'd0;
      b_rdata_q    <= 16'd0;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      err_q        <= err_d;
    end
  end

  // Strobes decode straight from state so reset kills them without waiting for a clock.
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en && (rw_q == RW_WT);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_done    = (state_q == S_DONE) && !owner_q;
  assign b_done    = (state_q == S_DONE) &&  owner_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round robin, reset abort, error flags.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  a_rw, b_rw;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [15:0] a_rdata, b_rdata;
  logic        a_done, b_done;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;
  logic [1:0]  err;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [15:0] wr_addr = 16'd0;
  logic [15:0] wr_data = 16'd0;

  mem_arbiter #(.LATENCY(100)) dut (
    .clk(clk), .reset(reset),
    .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_done(a_done),
    .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_done(b_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] rom(input logic [15:0] addr);
    case (addr)
      16'h0010: rom = 16'hBEEF;
      16'h0020: rom = 16'h1111;
      16'h0030: rom = 16'h2222;
      default:  rom = 16'hDEAD;
    endcase
  endfunction

  // Memory model: read data one cycle after the strobe, writes recorded.
  initial mem_rdata = 16'd0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end else begin
        mem_rdata <= rom(mem_addr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    a_rw = 2'b00; a_addr = 16'd0; a_wdata = 16'd0;
    b_rw = 2'b00; b_addr = 16'd0; b_wdata = 16'd0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(1);

    // A reads 0x0010 alone
    a_rw = 2'b01; a_addr = 16'h0010;
    check("rd_idle_busy", 32'(busy), 32'd0);
    tick(1);
    check("rd_c1_busy", 32'(busy), 32'd1);
    check("rd_c1_owner", 32'(owner), 32'd0);
    tick(99);
    check("rd_c100_en", 32'(mem_en), 32'd0);
    tick(1);
    check("rd_c101_en", 32'(mem_en), 32'd1);
    check("rd_c101_we", 32'(mem_we), 32'd0);
    check("rd_c101_addr", 32'(mem_addr), 32'h0010);
    tick(1);
    check("rd_c102_en", 32'(mem_en), 32'd0);
    check("rd_c102_done", 32'(a_done), 32'd0);
    tick(1);
    check("rd_c103_done", 32'(a_done), 32'd1);
    check("rd_c103_rdata", 32'(a_rdata), 32'hBEEF);
    check("rd_c103_bdone", 32'(b_done), 32'd0);
    tick(1);
    a_rw = 2'b00;
    check("rd_c104_done", 32'(a_done), 32'd0);
    check("rd_c104_busy", 32'(busy), 32'd0);

    // B writes 0x5A5A to 0x1234
    b_rw = 2'b10; b_addr = 16'h1234; b_wdata = 16'h5A5A;
    tick(101);
    check("wt_c101_en", 32'(mem_en), 32'd1);
    check("wt_c101_we", 32'(mem_we), 32'd1);
    check("wt_c101_addr", 32'(mem_addr), 32'h1234);
    check("wt_c101_wdata", 32'(mem_wdata), 32'h5A5A);
    check("wt_c101_owner", 32'(owner), 32'd1);
    tick(1);
    check("wt_c102_bdone", 32'(b_done), 32'd1);
    check("wt_c102_adone", 32'(a_done), 32'd0);
    tick(1);
    b_rw = 2'b00;
    check("wt_count", 32'(wr_cnt), 32'd1);
    check("wt_mem_addr", 32'(wr_addr), 32'h1234);
    check("wt_mem_data", 32'(wr_data), 32'h5A5A);
    check("wt_a_rdata_kept", 32'(a_rdata), 32'hBEEF);
    check("wt_b_rdata_kept", 32'(b_rdata), 32'd0);
    check("wt_addr_held", 32'(mem_addr), 32'h1234);
    check("wt_en_low", 32'(mem_en), 32'd0);

    // Simultaneous reads after reset: A, then B, then A again
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("rr_rst_rdata", 32'(a_rdata), 32'd0);
    tick(1);
    a_rw = 2'b01; a_addr = 16'h0020;
    b_rw = 2'b01; b_addr = 16'h0030;
    tick(1);
    check("rr_first_owner", 32'(owner), 32'd0);
    tick(102);
    check("rr_a_done", 32'(a_done), 32'd1);
    check("rr_a_rdata", 32'(a_rdata), 32'h1111);
    check("rr_b_not_done", 32'(b_done), 32'd0);
    tick(1);
    a_rw = 2'b00;
    check("rr_gap_idle", 32'(busy), 32'd0);
    tick(1);
    check("rr_second_owner", 32'(owner), 32'd1);
    check("rr_second_busy", 32'(busy), 32'd1);
    tick(102);
    check("rr_b_done", 32'(b_done), 32'd1);
    check("rr_b_rdata", 32'(b_rdata), 32'h2222);
    check("rr_a_rdata_kept", 32'(a_rdata), 32'h1111);
    tick(1);
    a_rw = 2'b01;
    tick(1);
    check("rr_third_owner", 32'(owner), 32'd0);
    tick(102);
    check("rr_third_done", 32'(a_done), 32'd1);
    tick(1);
    a_rw = 2'b00; b_rw = 2'b00;
    tick(1);
    check("rr_end_idle", 32'(busy), 32'd0);

    // Reset during WAIT of A's write aborts it
    a_rw = 2'b10; a_addr = 16'h0040; a_wdata = 16'h7777;
    tick(50);
    check("ab_wait_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("ab_busy_now", 32'(busy), 32'd0);
    check("ab_en_now", 32'(mem_en), 32'd0);
    a_rw = 2'b00;
    tick(1);
    check("ab_no_done", 32'(a_done), 32'd0);
    check("ab_no_write", 32'(wr_cnt), 32'd1);
    reset = 1'b1;
    tick(1);
    a_rw = 2'b10;
    tick(100);
    check("ab_c100_en", 32'(mem_en), 32'd0);
    tick(1);
    check("ab_c101_en", 32'(mem_en), 32'd1);
    check("ab_c101_we", 32'(mem_we), 32'd1);
    check("ab_c101_addr", 32'(mem_addr), 32'h0040);
    tick(1);
    check("ab_c102_done", 32'(a_done), 32'd1);
    check("ab_write_count", 32'(wr_cnt), 32'd2);
    check("ab_write_data", 32'(wr_data), 32'h7777);
    tick(1);
    a_rw = 2'b00;

    // Owner changes rw mid-transaction; then an illegal code in IDLE
    a_rw = 2'b01; a_addr = 16'h0010;
    tick(10);
    check("er_before", 32'(err), 32'd0);
    a_rw = 2'b10;
    tick(1);
    check("er_mismatch", 32'(err), 32'b01);
    tick(90);
    check("er_c101_en", 32'(mem_en), 32'd1);
    check("er_c101_we", 32'(mem_we), 32'd0);
    check("er_c101_addr", 32'(mem_addr), 32'h0010);
    tick(2);
    check("er_c103_done", 32'(a_done), 32'd1);
    check("er_c103_rdata", 32'(a_rdata), 32'hBEEF);
    tick(1);
    a_rw = 2'b11;
    tick(1);
    check("er_illegal", 32'(err), 32'b11);
    check("er_no_grant", 32'(busy), 32'd0);
    a_rw = 2'b00;
    tick(2);
    check("er_sticky", 32'(err), 32'b11);
    check("er_still_idle", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("er_reset_clear", 32'(err), 32'd0);
    check("er_reset_owner", 32'(owner), 32'd0);
    reset = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 100, memory wait cycles before access; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports a_rw / b_rw  input  2  request code: 00 IDEL, 01 RD, 10 WT, 11 illegal.
REQ-005 SHALL have ports a_addr / b_addr  input  16  word address.
REQ-006 SHALL have ports a_wdata / b_wdata  input  16  write data.
REQ-007 SHALL have ports a_rdata / b_rdata  output  16  read data returned to that requester.
REQ-008 SHALL have ports a_done / b_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports mem_en, mem_we  output  1 each  memory strobe and write select.
REQ-010 SHALL have ports mem_addr, mem_wdata  output  16 each  memory address and write data.
REQ-011 SHALL have port mem_rdata  input  16  memory read data, valid the cycle after mem_en with mem_we=0.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port owner  output  1  0 = A, 1 = B; current or last granted requester.
REQ-014 SHALL have port err  output  2  sticky error flags.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACCESS, CAPTURE and DONE.
REQ-016 IDLE SHALL grant when either rw is RD/WT; one requester active -> grant it; both active -> grant the requester not in last_owner (round robin).
REQ-017 On grant, SHALL latch rw/addr/wdata of the winner, set owner, load 8-bit counter with LATENCY-1, and go to WAIT.
REQ-018 WAIT SHALL decrement counter each cycle and go to ACCESS the cycle counter==0; WAIT lasts exactly LATENCY cycles.
REQ-019 ACCESS SHALL last one cycle: mem_en=1, mem_we=1 for WT / 0 for RD, mem_addr/mem_wdata = latched values; next state CAPTURE for RD, DONE for WT.
REQ-020 CAPTURE SHALL register mem_rdata into owner's rdata at end of cycle; next state DONE.
REQ-021 DONE SHALL assert owner's done for exactly one cycle, update last_owner=owner, and return to IDLE.
REQ-022 Latency, with the IDLE grant cycle as cycle 0: read done in cycle LATENCY+3, write done in cycle LATENCY+2.
REQ-023 mem_en SHALL be 0 outside ACCESS; mem_addr/mem_wdata SHALL hold the last latched values.
REQ-024 rdata of each requester SHALL hold its value until that requester's next read completes; the non-owner's rdata is never modified.
REQ-025 Requester SHALL hold rw/addr/wdata stable until its done, and present its next request or IDEL from the cycle after done; the arbiter samples again in the following IDLE cycle.
REQ-026 Back-to-back requests SHALL incur one IDLE cycle between DONE and the next grant.
REQ-027 err[0] SHALL set if owner's rw differs from the latched rw during WAIT, ACCESS or CAPTURE; the transaction continues with the latched values.
REQ-028 err[1] SHALL set if code 11 is seen on a requester in IDLE; that requester is treated as IDEL.
REQ-029 err bits SHALL clear only on reset.

Reset
REQ-030 reset low SHALL immediately force state=IDLE, counter=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, a/b_rdata=0, a/b_done=0, busy=0, owner=0, last_owner=1 (B), err=00.
REQ-031 Reset mid-transaction SHALL abort without done and without mem_en; a pending write is not performed if reset precedes ACCESS.
REQ-032 First grant after reset SHALL go to A if A and B request simultaneously.

Verification
REQ-033 A RD 0x0010 alone, mem_rdata=0x BEEF, LATENCY=100 -> mem_en pulse in cycle 101 with mem_we=0; a_done in cycle 103; a_rdata=0xBEEF.
REQ-034 B WT 0x1234<-0x5A5A -> mem_en=1, mem_we=1, mem_addr=0x1234, mem_wdata=0x5A5A in cycle 101; b_done in cycle 102; a_done stays 0.
REQ-035 A and B RD together after reset -> A served first, B granted in the IDLE cycle after a_done; third simultaneous pair -> A (round robin); owner toggles 0,1,0.
REQ-036 Reset low in WAIT cycle 50 of A's WT -> busy=0 immediately, no mem_en, no a_done; after release, new request takes full LATENCY.
REQ-037 A changes a_rw RD->WT during WAIT -> err=01, read still performed at the original address, a_done as normal; a_rw=11 in IDLE -> err=11, no grant.
